ntt_ctrl: RTL and testbench

- Sequencer for one `butterfly` datapath.
- Runs a complete 256-point NTT or inverse NTT, layer by layer, over a dual-port coefficient RAM. Supports Kyber (7 layers) and Dilithium (8 layers).
- Per cycle it generates the read addresses, the twiddle-ROM index and the butterfly mode selects, plus delay-matched write-back addresses and write enable.
- Sits between the polynomial-arithmetic top-level FSM and the RAM, twiddle ROM and butterfly.

---
 rtl/ntt_ctrl.sv | 152 +++++++++++++++
 tb/tb_ntt_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// Layer-by-layer sequencer for a 256-point NTT / inverse NTT over one butterfly.
// Issues read addresses, twiddle index and mode selects; write-back is the read stream delayed by WB_LAT.
module ntt_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       sel_red_i,
    input  logic       sel_butterfly_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] layer_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] twiddle_idx_o,
    output logic       sel_red_o,
    output logic       sel_butterfly_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam int unsigned WB_LAT = RD_LAT + BF_LAT;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] layer_nxt;
    logic [6:0] j, j_nxt;
    logic [3:0] dcnt, dcnt_nxt;
    logic       red_nxt, inv_nxt;
    logic       last_layer;

    logic [2:0] sh;
    logic [3:0] sh1;
    logic [7:0] len, grp, ofs, addr_a, addr_b, tw_idx;

    assign last_layer = (layer_o == (sel_red_o ? 3'd6 : 3'd7));

    always_comb begin
        state_nxt = state;
        layer_nxt = layer_o;
        j_nxt     = j;
        dcnt_nxt  = dcnt;
        red_nxt   = sel_red_o;
        inv_nxt   = sel_butterfly_o;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_RUN;
                    layer_nxt = '0;
                    j_nxt     = '0;
                    red_nxt   = sel_red_i;
                    inv_nxt   = sel_butterfly_i;
                end
            end
            S_RUN: begin
                if (j == 7'd127) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = '0;
                end else begin
                    j_nxt = j + 7'd1;
                end
            end
            S_DRAIN: begin
                if (dcnt == 4'(WB_LAT - 1)) begin
                    if (last_layer) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                        layer_nxt = layer_o + 3'd1;
                        j_nxt     = '0;
                    end
                end else begin
                    dcnt_nxt = dcnt + 4'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Addresses are computed from the next-cycle counters so they can be registered alongside rd_en_o.
    always_comb begin
        sh = '0;
        if (!inv_nxt)
            sh = 3'd7 - layer_nxt;
        else if (red_nxt)
            sh = layer_nxt + 3'd1;
        else
            sh = layer_nxt;
        sh1    = {1'b0, sh} + 4'd1;
        len    = 8'd1 << sh;
        grp    = {1'b0, j_nxt} >> sh;
        ofs    = {1'b0, j_nxt} & (len - 8'd1);
        addr_a = (grp << sh1) + ofs;
        addr_b = addr_a + len;
        // 256/len - 1 equals 8'hFF >> log2(len)
        tw_idx = inv_nxt ? ((8'hFF >> sh) - grp) : ((8'd1 << (3'd7 - sh)) + grp);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            j               <= '0;
            dcnt            <= '0;
            layer_o         <= '0;
            sel_red_o       <= 1'b0;
            sel_butterfly_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            rd_en_o         <= 1'b0;
            rd_addr_a_o     <= '0;
            rd_addr_b_o     <= '0;
            twiddle_idx_o   <= '0;
        end else begin
            state           <= state_nxt;
            j               <= j_nxt;
            dcnt            <= dcnt_nxt;
            layer_o         <= layer_nxt;
            sel_red_o       <= red_nxt;
            sel_butterfly_o <= inv_nxt;
            busy_o          <= (state_nxt != S_IDLE);
            done_o          <= (state_nxt == S_DONE);
            rd_en_o         <= (state_nxt == S_RUN);
            if (state_nxt == S_RUN) begin
                rd_addr_a_o   <= addr_a;
                rd_addr_b_o   <= addr_b;
                twiddle_idx_o <= tw_idx;
            end
        end
    end

    logic [16:0] wb_pipe [WB_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < WB_LAT; i++)
                wb_pipe[i] <= '0;
        end else begin
            wb_pipe[0] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
            for (int unsigned i = 1; i < WB_LAT; i++)
                wb_pipe[i] <= wb_pipe[i-1];
        end
    end

    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = wb_pipe[WB_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: a nested-loop software NTT order model feeds expected transactions,
// a negedge monitor compares two instances (default and RD_LAT=2/BF_LAT=0) against it.
module tb_ntt_ctrl;

    localparam int WB_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, start_i, sel_red_i, sel_bf_i;
    logic       busy[2], done[2], rd_en[2], sr[2], sb[2], wr_en[2];
    logic [2:0] layer[2];
    logic [7:0] rd_a[2], rd_b[2], tw[2], wr_a[2], wr_b[2];

    ntt_ctrl u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sel_red_i(sel_red_i),
        .sel_butterfly_i(sel_bf_i), .busy_o(busy[0]), .done_o(done[0]), .layer_o(layer[0]),
        .rd_en_o(rd_en[0]), .rd_addr_a_o(rd_a[0]), .rd_addr_b_o(rd_b[0]),
        .twiddle_idx_o(tw[0]), .sel_red_o(sr[0]), .sel_butterfly_o(sb[0]),
        .wr_en_o(wr_en[0]), .wr_addr_a_o(wr_a[0]), .wr_addr_b_o(wr_b[0])
    );

    ntt_ctrl #(.RD_LAT(2), .BF_LAT(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sel_red_i(sel_red_i),
        .sel_butterfly_i(sel_bf_i), .busy_o(busy[1]), .done_o(done[1]), .layer_o(layer[1]),
        .rd_en_o(rd_en[1]), .rd_addr_a_o(rd_a[1]), .rd_addr_b_o(rd_b[1]),
        .twiddle_idx_o(tw[1]), .sel_red_o(sr[1]), .sel_butterfly_o(sb[1]),
        .wr_en_o(wr_en[1]), .wr_addr_a_o(wr_a[1]), .wr_addr_b_o(wr_b[1])
    );

    typedef struct packed {
        logic [2:0] layer;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tw;
        logic       red;
        logic       inv;
    } rd_t;

    rd_t exp_rd[$];
    int  exp_done[$];
    int  rp[2], wp[2], dp[2];
    int  rd_cyc[2][1024];
    int  cyc = 0;
    bit  chk_zero = 1'b0;
    int  spot_run = -1;
    int  vectors = 0, miscompares = 0;

    // {run, layer, j, a, b, twiddle}
    int spot[9][6] = '{
        '{0, 0,   0,   0, 128,   1}, '{0, 0, 127, 127, 255,   1},
        '{0, 1,  64, 128, 192,   3}, '{0, 6, 127, 253, 255, 127},
        '{1, 7,   5,  10,  11, 133},
        '{2, 0,   0,   0,   1, 255}, '{2, 7,   0,   0, 128,   1},
        '{3, 0,   0,   0,   2, 127}, '{3, 6,   0,   0, 128,   1}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d: got 0x%0h expected 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int k);
        vectors++;
        miscompares++;
        $display("FAIL %s dut%0d cyc=%0d: got event expected none", name, k, cyc);
    endtask

    always @(negedge clk) begin : mon
        rd_t e;
        for (int k = 0; k < 2; k++) begin
            if (chk_zero) begin
                check("reset_outputs", k,
                      {busy[k], done[k], layer[k], rd_en[k], rd_a[k], rd_b[k], tw[k],
                       sr[k], sb[k], wr_en[k], wr_a[k], wr_b[k]}, '0);
            end else begin
                if (rd_en[k] === 1'b1) begin
                    if (rp[k] < exp_rd.size()) begin
                        e = exp_rd[rp[k]];
                        check("rd", k, {busy[k], layer[k], rd_a[k], rd_b[k], tw[k], sr[k], sb[k]},
                              {1'b1, e});
                        if (rp[k] % 128 == 0 && rp[k] > 0) begin
                            check("raw_order", k, wp[k], rp[k]);
                            check("drain_len", k, cyc - rd_cyc[k][rp[k]-1], WB_LAT + 1);
                        end
                        for (int s = 0; s < 9; s++)
                            if (spot[s][0] == spot_run && spot[s][1] == rp[k] / 128 && spot[s][2] == rp[k] % 128)
                                check("spot", k, {rd_a[k], rd_b[k], tw[k]},
                                      64'((spot[s][3] << 16) | (spot[s][4] << 8) | spot[s][5]));
                        rd_cyc[k][rp[k]] = cyc;
                        rp[k]++;
                    end else
                        unexpected("rd_extra", k);
                end
                if (wr_en[k] === 1'b1) begin
                    if (wp[k] < rp[k]) begin
                        e = exp_rd[wp[k]];
                        check("wr_addr", k, {wr_a[k], wr_b[k]}, {e.a, e.b});
                        check("wr_latency", k, cyc - rd_cyc[k][wp[k]], WB_LAT);
                        wp[k]++;
                    end else
                        unexpected("wr_extra", k);
                end
                if (done[k] === 1'b1) begin
                    if (dp[k] < exp_done.size()) begin
                        check("done_cycle", k, cyc, exp_done[dp[k]]);
                        check("done_busy", k, busy[k], 1);
                        dp[k]++;
                    end else
                        unexpected("done_extra", k);
                end
            end
        end
        chk_zero = 1'b0;
    end

    task automatic gen_model(input logic red, input logic inv);
        int len, tk, l;
        l = 0;
        if (!inv) begin
            tk = 1;
            for (len = 128; len >= (red ? 2 : 1); len = len / 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int x = s; x < s + len; x++)
                        exp_rd.push_back(rd_t'({3'(l), 8'(x), 8'(x + len), 8'(tk), red, inv}));
                    tk++;
                end
                l++;
            end
        end else begin
            tk = red ? 127 : 255;
            for (len = (red ? 2 : 1); len <= 128; len = len * 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int x = s; x < s + len; x++)
                        exp_rd.push_back(rd_t'({3'(l), 8'(x), 8'(x + len), 8'(tk), red, inv}));
                    tk--;
                end
                l++;
            end
        end
    endtask

    task automatic clear_sb();
        exp_rd.delete();
        exp_done.delete();
        for (int k = 0; k < 2; k++) begin
            rp[k] = 0; wp[k] = 0; dp[k] = 0;
        end
    endtask

    task automatic run(input logic red, input logic inv, input int spot_id, input bit glitch, input int rst_at);
        int nl, wcount;
        nl = red ? 7 : 8;
        clear_sb();
        gen_model(red, inv);
        spot_run  = spot_id;
        sel_red_i = red;
        sel_bf_i  = inv;
        start_i   = 1'b1;
        exp_done.push_back(cyc + 1 + nl * (128 + WB_LAT));
        @(negedge clk); #1;
        start_i = 1'b0;
        for (int t = 0; t < 1200; t++) begin
            if (dp[0] >= 1 && dp[1] >= 1) break;
            if (rst_at > 0 && rp[0] == rst_at) begin
                rst_i = 1'b1;
                clear_sb();
                chk_zero = 1'b1;
                @(negedge clk); #1;
                rst_i  = 1'b0;
                wcount = 0;
                repeat (12) begin
                    @(negedge clk); #1;
                    wcount += int'(wr_en[0]) + int'(wr_en[1]);
                end
                check("no_wr_after_rst", 0, wcount, 0);
                return;
            end
            if (glitch && t == 300) begin
                start_i = 1'b1; sel_red_i = ~red; sel_bf_i = ~inv;
            end else if (glitch && t == 301) begin
                start_i = 1'b0; sel_red_i = red; sel_bf_i = inv;
            end
            @(negedge clk); #1;
        end
        if (!(dp[0] >= 1 && dp[1] >= 1)) begin
            vectors++; miscompares++;
            $display("FAIL timeout run%0d: got no done_o expected done_o within budget", spot_id);
        end
        repeat (WB_LAT + 3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rd_total", k, rp[k], nl * 128);
            check("wr_total", k, wp[k], nl * 128);
            check("done_count", k, dp[k], 1);
            check("idle_flags", k, {busy[k], done[k]}, 0);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; sel_red_i = 1'b0; sel_bf_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_zero = 1'b1;
        @(negedge clk);
        #1 rst_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        run(1'b1, 1'b0, 0, 1'b0, 0);    // forward Kyber
        run(1'b0, 1'b0, 1, 1'b1, 0);    // forward Dilithium, start/mode toggled mid-run
        run(1'b0, 1'b1, 2, 1'b0, 0);    // inverse Dilithium
        run(1'b1, 1'b1, 3, 1'b0, 0);    // inverse Kyber
        run(1'b1, 1'b0, 0, 1'b0, 297);  // reset after L2 j=40
        run(1'b1, 1'b0, 0, 1'b0, 0);    // full transform after reset
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
